// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the bit-serial adder:
//   - state_e        : FSM state encoding (IDLE / SHIFT / FINISH)
//   - WIDTH_MIN/MAX  : legal operand width range
//   - width_ok()     : elaboration-time check of a WIDTH value
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

    // True when w is a supported operand width.
    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//
// Combinational single-bit full adder. The serial adder pushes one operand bit
// pair per clock through this cell.
//
// Ports:
//   A      in  1  operand A bit
//   B      in  1  operand B bit
//   C_IN   in  1  carry-in
//   SUM    out 1  A ^ B ^ C_IN
//   C_OUT  out 1  majority(A, B, C_IN)
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic A,
    input  logic B,
    input  logic C_IN,
    output logic SUM,
    output logic C_OUT
);

    logic half_sum;

    assign half_sum = A ^ B;
    assign SUM      = half_sum ^ C_IN;
    // Generate when both operand bits are set, propagate the incoming carry
    // when exactly one is set.
    assign C_OUT    = (A & B) | (C_IN & half_sum);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. On an accepted START the operands and carry-in
// are captured; the design then adds one bit per clock, LSB first, through a
// single fa_cell with a registered carry, and reassembles the sum bits into a
// parallel result. Latency is WIDTH cycles of SHIFT plus one FINISH cycle.
//
// Parameters:
//   WIDTH    operand/result width, 2..32 (default 8)
//
// Ports:
//   CLK      in  1      clock, rising edge
//   RST      in  1      asynchronous active-high reset
//   START    in  1      request, sampled only in IDLE
//   A_IN     in  WIDTH  operand A, captured on accepted START
//   B_IN     in  WIDTH  operand B, captured on accepted START
//   C_IN     in  1      carry-in, captured on accepted START
//   BUSY     out 1      high while in SHIFT
//   DONE     out 1      one-cycle pulse when SUM_OUT/C_OUT are fresh
//   SUM_OUT  out WIDTH  registered sum, held until the next completion
//   C_OUT    out 1      registered carry-out of the MSB, held with SUM_OUT
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM_OUT,
    output logic             C_OUT
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("serial_adder: WIDTH=%0d outside supported range %0d..%0d",
                   WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   a_sh_q,    a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,    b_sh_d;
    // Collected sum bits. Only WIDTH-1 bits are stored: the bit entering on
    // the final shift goes straight into SUM_OUT, so the oldest position of a
    // full WIDTH-bit shifter would never be read.
    logic [WIDTH-2:0]   sum_sh_q,  sum_sh_d;
    logic               carry_q,   carry_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   sum_out_q, sum_out_d;
    logic               c_out_q,   c_out_d;

    // -------------------------------------------------------------------------
    // Single adder cell: LSBs of the operand shifters plus the carry flop.
    // -------------------------------------------------------------------------
    logic fa_sum;
    logic fa_cout;

    fa_cell u_fa (
        .A     (a_sh_q[0]),
        .B     (b_sh_q[0]),
        .C_IN  (carry_q),
        .SUM   (fa_sum),
        .C_OUT (fa_cout)
    );

    // New bit enters at the MSB and everything collected so far moves down
    // one place. After the last shift this is the complete sum.
    logic [WIDTH-1:0] sum_next;
    assign sum_next = {fa_sum, sum_sh_q};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // through the case leaves one unassigned and infers a latch.
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_out_d = sum_out_q;
        c_out_d   = c_out_q;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_sh_d  = A_IN;
                    b_sh_d  = B_IN;
                    carry_d = C_IN;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                sum_sh_d = sum_next[WIDTH-1:1];
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_cout;
                // Wraps to zero on the last bit for power-of-two widths; the
                // count is reloaded before it is used again.
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_out_d = sum_next;
                    c_out_d   = fa_cout;
                    state_d   = ST_FINISH;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_out_q <= '0;
            c_out_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_out_q <= sum_out_d;
            c_out_q   <= c_out_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: status decoded purely from the state register, results from
    // their own registers, so nothing on the outputs depends on inputs
    // combinationally.
    // -------------------------------------------------------------------------
    assign BUSY    = (state_q == ST_SHIFT);
    assign DONE    = (state_q == ST_FINISH);
    assign SUM_OUT = sum_out_q;
    assign C_OUT   = c_out_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16. Directed
// vectors come from a table; corner cases (START re-pulse, reset mid-shift)
// are hand-written sequences; a held-START random run is checked against an
// arithmetic reference model (A + B + C_IN) through a queue per instance.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W8  = 8;
    localparam int W16 = 16;

    logic           CLK;
    logic           RST;

    logic           START8;
    logic [W8-1:0]  A8, B8;
    logic           C8;
    logic           BUSY8, DONE8;
    logic [W8-1:0]  SUM8;
    logic           COUT8;

    logic           START16;
    logic [W16-1:0] A16, B16;
    logic           C16;
    logic           BUSY16, DONE16;
    logic [W16-1:0] SUM16;
    logic           COUT16;

    serial_adder #(.WIDTH(W8)) dut8 (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START8),
        .A_IN    (A8),
        .B_IN    (B8),
        .C_IN    (C8),
        .BUSY    (BUSY8),
        .DONE    (DONE8),
        .SUM_OUT (SUM8),
        .C_OUT   (COUT8)
    );

    serial_adder #(.WIDTH(W16)) dut16 (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START16),
        .A_IN    (A16),
        .B_IN    (B16),
        .C_IN    (C16),
        .BUSY    (BUSY16),
        .DONE    (DONE16),
        .SUM_OUT (SUM16),
        .C_OUT   (COUT16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete 8-bit operation with cycle-accurate status checks.
    // Called at #1 after an edge with the DUT in IDLE; returns at #1 after the
    // edge that ends DONE, with the DUT back in IDLE.
    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] exp_sum, input logic exp_cout);
        int busy_cycles;
        int done_at;
        START8 = 1'b1;
        A8 = a;
        B8 = b;
        C8 = c;
        @(posedge CLK); #1;
        // Accepted: drop START and disturb the operand inputs.
        START8 = 1'b0;
        A8 = 8'($urandom);
        B8 = 8'($urandom);
        C8 = 1'($urandom);
        busy_cycles = 0;
        done_at     = -1;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            if (BUSY8) busy_cycles++;
            if (DONE8) done_at = i;
            else begin
                @(posedge CLK); #1;
            end
        end
        check({name, "_done_latency"}, 64'(done_at), 64'(W8));
        check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(W8));
        check({name, "_sum"}, 64'(SUM8), 64'(exp_sum));
        check({name, "_cout"}, 64'(COUT8), 64'(exp_cout));
        @(posedge CLK); #1;
        check({name, "_done_pulse"}, 64'(DONE8), 64'(0));
    endtask

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[8];

    logic [W8:0]  q8[$];
    logic [W16:0] q16[$];
    int got8, last8, got16, last16;

    // Global time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [7:0] cap_sum;
        logic       cap_cout;

        vecs[0] = '{"v3c_0a",   8'h3C, 8'h0A, 1'b0, 8'h46, 1'b0};
        vecs[1] = '{"vff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{"vff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{"v80_80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{"v55_aa",   8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{"v7f_01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{"v00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[7] = '{"vc3_5a_c", 8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1};

        RST = 1'b0;
        START8 = 1'b0;  A8 = '0;  B8 = '0;  C8 = 1'b0;
        START16 = 1'b0; A16 = '0; B16 = '0; C16 = 1'b0;

        // ---- Reset: outputs clear without any clock edge ---------------------
        #1 RST = 1'b1;
        #1;
        check("rst_busy", 64'(BUSY8), 64'(0));
        check("rst_done", 64'(DONE8), 64'(0));
        check("rst_sum",  64'(SUM8),  64'(0));
        check("rst_cout", 64'(COUT8), 64'(0));
        check("rst_busy16", 64'(BUSY16), 64'(0));
        @(posedge CLK); #1;
        RST = 1'b0;

        // ---- Table-driven directed vectors -----------------------------------
        foreach (vecs[i])
            op8(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

        // ---- START re-pulsed during SHIFT is ignored -------------------------
        START8 = 1'b1; A8 = 8'h3C; B8 = 8'h0A; C8 = 1'b0;
        @(posedge CLK); #1;
        START8 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        START8 = 1'b1; A8 = 8'h11; B8 = 8'h22; C8 = 1'b1;
        @(posedge CLK); #1;
        START8 = 1'b0;
        dones = 0;
        cap_sum = '0;
        cap_cout = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (DONE8) begin
                dones++;
                cap_sum  = SUM8;
                cap_cout = COUT8;
            end
            @(posedge CLK); #1;
        end
        check("repulse_done_count", 64'(dones), 64'(1));
        check("repulse_sum", 64'(cap_sum), 64'(8'h46));
        check("repulse_cout", 64'(cap_cout), 64'(0));

        // ---- Reset at cnt=4 aborts at once -----------------------------------
        START8 = 1'b1; A8 = 8'hFF; B8 = 8'hFF; C8 = 1'b1;
        @(posedge CLK); #1;
        START8 = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("midrst_busy_before", 64'(BUSY8), 64'(1));
        RST = 1'b1;
        #1;
        check("midrst_busy", 64'(BUSY8), 64'(0));
        check("midrst_done", 64'(DONE8), 64'(0));
        check("midrst_sum",  64'(SUM8),  64'(0));
        check("midrst_cout", 64'(COUT8), 64'(0));
        @(posedge CLK); #1;
        RST = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (DONE8) dones++;
            @(posedge CLK); #1;
        end
        check("midrst_no_done", 64'(dones), 64'(0));
        check("midrst_sum_held", 64'(SUM8), 64'(0));
        op8("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // ---- START held high, random operands, both widths -------------------
        got8 = 0;  last8 = -1;
        got16 = 0; last16 = -1;
        fork
            begin : drv8
                for (int n = 0; n < 200; n++) begin
                    A8 = 8'($urandom);
                    B8 = 8'($urandom);
                    C8 = 1'($urandom);
                    q8.push_back({1'b0, A8} + {1'b0, B8} + 9'(C8));
                    START8 = 1'b1;
                    @(posedge CLK); #1;
                    A8 = 8'($urandom);
                    B8 = 8'($urandom);
                    C8 = 1'($urandom);
                    repeat (W8 + 1) @(posedge CLK);
                    #1;
                end
                START8 = 1'b0;
            end
            begin : mon8
                for (int cyc = 0; cyc < 200 * (W8 + 2) + 50 && got8 < 200; cyc++) begin
                    @(posedge CLK); #1;
                    if (DONE8) begin
                        if (q8.size() == 0)
                            check("rnd8_unexpected_done", 64'(1), 64'(0));
                        else
                            check("rnd8_result", 64'({COUT8, SUM8}), 64'(q8.pop_front()));
                        if (last8 >= 0)
                            check("rnd8_spacing", 64'(cyc - last8), 64'(W8 + 2));
                        last8 = cyc;
                        got8++;
                    end
                end
                check("rnd8_done_count", 64'(got8), 64'(200));
            end
            begin : drv16
                for (int n = 0; n < 200; n++) begin
                    A16 = 16'($urandom);
                    B16 = 16'($urandom);
                    C16 = 1'($urandom);
                    q16.push_back({1'b0, A16} + {1'b0, B16} + 17'(C16));
                    START16 = 1'b1;
                    @(posedge CLK); #1;
                    A16 = 16'($urandom);
                    B16 = 16'($urandom);
                    C16 = 1'($urandom);
                    repeat (W16 + 1) @(posedge CLK);
                    #1;
                end
                START16 = 1'b0;
            end
            begin : mon16
                for (int cyc = 0; cyc < 200 * (W16 + 2) + 50 && got16 < 200; cyc++) begin
                    @(posedge CLK); #1;
                    if (DONE16) begin
                        if (q16.size() == 0)
                            check("rnd16_unexpected_done", 64'(1), 64'(0));
                        else
                            check("rnd16_result", 64'({COUT16, SUM16}), 64'(q16.pop_front()));
                        if (last16 >= 0)
                            check("rnd16_spacing", 64'(cyc - last16), 64'(W16 + 2));
                        last16 = cyc;
                        got16++;
                    end
                end
                check("rnd16_done_count", 64'(got16), 64'(200));
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
